// File: rtl/ex_stage_md.sv
// Execute stage with operand forwarding, single-cycle ALU, iterative RV32M-style mul/div and EX/MEM register.
// ALU ops reach MEM one edge later; mul/div stalls upstream XLEN+1 cycles and feeds bubbles to MEM meanwhile.
module ex_stage_md #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_e,
    input  logic            flush_e,
    input  logic            reg_write_e,
    input  logic            load_e,
    input  logic            store_e,
    input  logic [1:0]      result_src_e,
    input  logic [3:0]      alu_ctrl_e,
    input  logic            md_en_e,
    input  logic [2:0]      md_op_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] store_data_e,
    input  logic [RA_W-1:0] rd_e,
    input  logic [XLEN-1:0] pc_plus4_e,
    input  logic [XLEN-1:0] instr_e,
    input  logic [1:0]      fwd_a_e,
    input  logic [1:0]      fwd_b_e,
    input  logic [XLEN-1:0] result_w,
    output logic            stall_ex,
    output logic            md_busy,
    output logic            valid_m,
    output logic            reg_write_m,
    output logic            load_m,
    output logic            store_m,
    output logic [1:0]      result_src_m,
    output logic [RA_W-1:0] rd_m,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pc_plus4_m,
    output logic [XLEN-1:0] instr_m,
    output logic [XLEN-1:0] result_e
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [SH_W-1:0] CNT_MAX = SH_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;

    logic [XLEN-1:0] src_a, src_b;
    logic [SH_W-1:0] count;
    logic [XLEN-1:0] hi, lo, mcand;
    logic [2:0]      op_q;
    logic            neg_main_q, neg_rem_q;

    logic            h_reg_write, h_load, h_store;
    logic [1:0]      h_result_src;
    logic [RA_W-1:0] h_rd;
    logic [XLEN-1:0] h_store_data, h_pc_plus4, h_instr;

    always_comb begin
        case (fwd_a_e)
            2'b00:   src_a = rd1_e;
            2'b01:   src_a = result_w;
            2'b10:   src_a = alu_result_m;
            default: src_a = '0;
        endcase
        case (fwd_b_e)
            2'b00:   src_b = rd2_e;
            2'b01:   src_b = result_w;
            2'b10:   src_b = alu_result_m;
            default: src_b = '0;
        endcase
    end

    // 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, others pass src_b
    always_comb begin
        case (alu_ctrl_e)
            4'd0:    result_e = src_a + src_b;
            4'd1:    result_e = src_a - src_b;
            4'd2:    result_e = src_a & src_b;
            4'd3:    result_e = src_a | src_b;
            4'd4:    result_e = src_a ^ src_b;
            4'd5:    result_e = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'd6:    result_e = {{(XLEN-1){1'b0}}, src_a < src_b};
            4'd7:    result_e = src_a << src_b[SH_W-1:0];
            4'd8:    result_e = src_a >> src_b[SH_W-1:0];
            4'd9:    result_e = $signed(src_a) >>> src_b[SH_W-1:0];
            default: result_e = src_b;
        endcase
    end

    logic            accept, a_sgn, b_sgn, a_neg, b_neg, neg_main;
    logic [XLEN-1:0] abs_a, abs_b;

    assign accept   = (state == IDLE) && valid_e && md_en_e && !flush_e;
    assign a_sgn    = md_op_e[2] ? !md_op_e[0] : (md_op_e[1:0] != 2'b11);
    assign b_sgn    = md_op_e[2] ? !md_op_e[0] : !md_op_e[1];
    assign a_neg    = a_sgn && src_a[XLEN-1];
    assign b_neg    = b_sgn && src_b[XLEN-1];
    assign abs_a    = a_neg ? -src_a : src_a;
    assign abs_b    = b_neg ? -src_b : src_b;
    // A zero divisor must yield an all-ones quotient regardless of dividend sign.
    assign neg_main = (a_neg ^ b_neg) && !(md_op_e[2] && (src_b == '0));

    logic [XLEN-1:0] mul_add;
    logic [XLEN:0]   mul_acc, div_sh, div_diff;
    logic            div_ge;

    assign mul_add  = lo[0] ? mcand : '0;
    assign mul_acc  = {1'b0, hi} + {1'b0, mul_add};
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mcand};
    assign div_ge   = div_sh >= {1'b0, mcand};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   md_result;

    always_comb begin
        prod_fix = neg_main_q ? -{hi, lo} : {hi, lo};
        case (op_q)
            3'b000:         md_result = prod_fix[XLEN-1:0];
            3'b100, 3'b101: md_result = neg_main_q ? -lo : lo;
            3'b110, 3'b111: md_result = neg_rem_q ? -hi : hi;
            default:        md_result = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = BUSY;
            BUSY:    if (count == CNT_MAX) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush_e) state_n = IDLE;
    end

    assign stall_ex = !rst && !flush_e && (accept || (state == BUSY));
    assign md_busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            hi           <= '0;
            lo           <= '0;
            mcand        <= '0;
            op_q         <= '0;
            neg_main_q   <= 1'b0;
            neg_rem_q    <= 1'b0;
            h_reg_write  <= 1'b0;
            h_load       <= 1'b0;
            h_store      <= 1'b0;
            h_result_src <= '0;
            h_rd         <= '0;
            h_store_data <= '0;
            h_pc_plus4   <= '0;
            h_instr      <= '0;
        end else if (accept) begin
            count        <= '0;
            hi           <= '0;
            lo           <= md_op_e[2] ? abs_a : abs_b;
            mcand        <= md_op_e[2] ? abs_b : abs_a;
            op_q         <= md_op_e;
            neg_main_q   <= neg_main;
            neg_rem_q    <= a_neg;
            h_reg_write  <= reg_write_e;
            h_load       <= load_e;
            h_store      <= store_e;
            h_result_src <= result_src_e;
            h_rd         <= rd_e;
            h_store_data <= store_data_e;
            h_pc_plus4   <= pc_plus4_e;
            h_instr      <= instr_e;
        end else if (state == BUSY) begin
            count <= count + 1'b1;
            if (op_q[2]) begin
                hi <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                lo <= {lo[XLEN-2:0], div_ge};
            end else begin
                hi <= mul_acc[XLEN:1];
                lo <= {mul_acc[0], lo[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            load_m       <= 1'b0;
            store_m      <= 1'b0;
            result_src_m <= '0;
            rd_m         <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
            instr_m      <= '0;
        end else if ((state == DONE) && !flush_e) begin
            valid_m      <= 1'b1;
            reg_write_m  <= h_reg_write;
            load_m       <= h_load;
            store_m      <= h_store;
            result_src_m <= h_result_src;
            rd_m         <= h_rd;
            alu_result_m <= md_result;
            write_data_m <= h_store_data;
            pc_plus4_m   <= h_pc_plus4;
            instr_m      <= h_instr;
        end else if ((state == IDLE) && valid_e && !md_en_e && !flush_e) begin
            valid_m      <= 1'b1;
            reg_write_m  <= reg_write_e;
            load_m       <= load_e;
            store_m      <= store_e;
            result_src_m <= result_src_e;
            rd_m         <= rd_e;
            alu_result_m <= result_e;
            write_data_m <= store_data_e;
            pc_plus4_m   <= pc_plus4_e;
            instr_m      <= instr_e;
        end else begin
            valid_m     <= 1'b0;
            reg_write_m <= 1'b0;
            load_m      <= 1'b0;
            store_m     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage_md.sv
// Directed and random bench for ex_stage_md against an arithmetic reference model (XLEN=32).
module tb_ex_stage_md;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_e, flush_e, reg_write_e, load_e, store_e, md_en_e;
    logic [1:0]      result_src_e, fwd_a_e, fwd_b_e;
    logic [3:0]      alu_ctrl_e;
    logic [2:0]      md_op_e;
    logic [XLEN-1:0] rd1_e, rd2_e, store_data_e, pc_plus4_e, instr_e, result_w;
    logic [RA_W-1:0] rd_e;
    logic            stall_ex, md_busy, valid_m, reg_write_m, load_m, store_m;
    logic [1:0]      result_src_m;
    logic [RA_W-1:0] rd_m;
    logic [XLEN-1:0] alu_result_m, write_data_m, pc_plus4_m, instr_m, result_e;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_m;

    ex_stage_md #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e),
        .reg_write_e(reg_write_e), .load_e(load_e), .store_e(store_e),
        .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e), .md_en_e(md_en_e),
        .md_op_e(md_op_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .store_data_e(store_data_e),
        .rd_e(rd_e), .pc_plus4_e(pc_plus4_e), .instr_e(instr_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .result_w(result_w),
        .stall_ex(stall_ex), .md_busy(md_busy), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .load_m(load_m), .store_m(store_m),
        .result_src_m(result_src_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m), .instr_m(instr_m),
        .result_e(result_e)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return 32'(sa >>> b[4:0]);
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint la, lb, lua, lub;
        logic [63:0] p;
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        lua = {32'd0, a};
        lub = {32'd0, b};
        case (op)
            3'd0: begin p = lua * lub; return p[31:0]; end
            3'd1: begin p = la * lb;   return p[63:32]; end
            3'd2: begin p = la * lub;  return p[63:32]; end
            3'd3: begin p = lua * lub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return ones;
                if (a == 32'h8000_0000 && b == ones) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? ones : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == ones) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] fwd_val(input logic [1:0] f, input logic [31:0] r);
        case (f)
            2'b00:   return r;
            2'b01:   return result_w;
            2'b10:   return exp_m;
            default: return 32'd0;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the instruction reached MEM.
    task automatic run_instr(input bit md, input logic [3:0] ctrl, input logic [2:0] op,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [1:0] fa, input logic [1:0] fb, input string tag);
        logic [31:0] exp, e_sd, e_pc, e_in;
        logic [4:0]  e_rd;
        logic        e_rw, e_ld, e_st;
        logic [1:0]  e_rs;
        int n, bad;
        exp  = md ? md_ref(op, fwd_val(fa, r1), fwd_val(fb, r2))
                  : alu_ref(ctrl, fwd_val(fa, r1), fwd_val(fb, r2));
        e_sd = $urandom; e_pc = $urandom; e_in = $urandom; e_rd = 5'($urandom);
        e_rw = 1'($urandom); e_ld = 1'($urandom); e_st = 1'($urandom); e_rs = 2'($urandom);
        valid_e = 1'b1; md_en_e = md; alu_ctrl_e = ctrl; md_op_e = op;
        rd1_e = r1; rd2_e = r2; fwd_a_e = fa; fwd_b_e = fb;
        store_data_e = e_sd; pc_plus4_e = e_pc; instr_e = e_in; rd_e = e_rd;
        reg_write_e = e_rw; load_e = e_ld; store_e = e_st; result_src_e = e_rs;
        #1;
        if (!md) begin
            check({tag, "_nostall"}, stall_ex, 1'b0);
            check({tag, "_result_e"}, result_e, exp);
        end else begin
            n = 0;
            bad = 0;
            while (stall_ex && n < 100) begin
                n++;
                if (n >= 2) begin
                    if (valid_m !== 1'b0) bad++;
                    rd1_e = $urandom; rd2_e = $urandom; result_w = $urandom;
                    fwd_a_e = 2'($urandom); fwd_b_e = 2'($urandom);
                end
                @(negedge clk);
                #1;
            end
            check({tag, "_stall_cycles"}, n, XLEN + 1);
            check({tag, "_bubbles"}, bad, 0);
            check({tag, "_busy_done"}, md_busy, 1'b1);
        end
        @(negedge clk);
        check({tag, "_result_m"}, alu_result_m, exp);
        check({tag, "_valid_m"}, valid_m, 1'b1);
        check({tag, "_ctrl_m"}, {reg_write_m, load_m, store_m, result_src_m, rd_m},
              {e_rw, e_ld, e_st, e_rs, e_rd});
        check({tag, "_pass_m"}, {write_data_m, pc_plus4_m}, {e_sd, e_pc});
        check({tag, "_instr_m"}, instr_m, e_in);
        exp_m = exp;
    endtask

    task automatic idle_cycle();
        valid_e = 1'b0;
        md_en_e = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; valid_e = 0; flush_e = 0; reg_write_e = 0; load_e = 0; store_e = 0;
        md_en_e = 0; result_src_e = 0; fwd_a_e = 0; fwd_b_e = 0; alu_ctrl_e = 0; md_op_e = 0;
        rd1_e = 0; rd2_e = 0; store_data_e = 0; pc_plus4_e = 0; instr_e = 0; rd_e = 0;
        result_w = 0; exp_m = 0;
        repeat (2) @(negedge clk);
        check("rst_stall", stall_ex, 1'b0);
        check("rst_busy", md_busy, 1'b0);
        check("rst_ctrl_m", {valid_m, reg_write_m, load_m, store_m, result_src_m, rd_m}, 0);
        check("rst_data_m", {alu_result_m, write_data_m}, 0);
        check("rst_pass_m", {pc_plus4_m, instr_m}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_instr(0, 4'd0, 3'd0, 32'd5, 32'd7, 2'b00, 2'b00, "add");
        check("add_plan", alu_result_m, 32'd12);
        idle_cycle();

        run_instr(1, 4'd0, 3'd0, 32'hFFFF_FFFF, 32'd3, 2'b00, 2'b00, "mul");
        check("mul_plan", alu_result_m, 32'hFFFF_FFFD);
        run_instr(1, 4'd0, 3'd1, 32'hFFFF_FFFF, 32'd3, 2'b00, 2'b00, "mulh");
        check("mulh_plan", alu_result_m, 32'hFFFF_FFFF);
        run_instr(1, 4'd0, 3'd3, 32'hFFFF_FFFF, 32'd3, 2'b00, 2'b00, "mulhu");
        check("mulhu_plan", alu_result_m, 32'd2);
        run_instr(1, 4'd0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00, "mulhsu");
        check("mulhsu_plan", alu_result_m, 32'hFFFF_FFFF);

        run_instr(1, 4'd0, 3'd4, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, "div");
        check("div_plan", alu_result_m, 32'hFFFF_FFFD);
        run_instr(1, 4'd0, 3'd6, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, "rem");
        check("rem_plan", alu_result_m, 32'hFFFF_FFFF);
        run_instr(1, 4'd0, 3'd5, 32'd7, 32'd0, 2'b00, 2'b00, "divu0");
        check("divu0_plan", alu_result_m, 32'hFFFF_FFFF);
        run_instr(1, 4'd0, 3'd6, 32'd7, 32'd0, 2'b00, 2'b00, "rem0");
        check("rem0_plan", alu_result_m, 32'd7);
        run_instr(1, 4'd0, 3'd4, 32'hFFFF_FFF9, 32'd0, 2'b00, 2'b00, "divneg0");
        check("divneg0_plan", alu_result_m, 32'hFFFF_FFFF);
        run_instr(1, 4'd0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, "divovf");
        check("divovf_plan", alu_result_m, 32'h8000_0000);
        run_instr(1, 4'd0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, "removf");
        check("removf_plan", alu_result_m, 32'd0);

        run_instr(0, 4'd0, 3'd0, 32'd4, 32'd5, 2'b00, 2'b00, "fwd_pre");
        run_instr(1, 4'd0, 3'd0, 32'h0000_DEAD, 32'd3, 2'b10, 2'b00, "fwd_mul");
        check("fwd_plan", alu_result_m, 32'd27);
        idle_cycle();

        // Flush after ten BUSY cycles: no result, previous MEM value retained.
        valid_e = 1; md_en_e = 1; md_op_e = 3'd0; rd1_e = 32'd11; rd2_e = 32'd13;
        fwd_a_e = 0; fwd_b_e = 0;
        repeat (11) @(negedge clk);
        check("flush_pre_busy", md_busy, 1'b1);
        flush_e = 1'b1;
        #1;
        check("flush_stall", stall_ex, 1'b0);
        @(negedge clk);
        flush_e = 1'b0; valid_e = 1'b0; md_en_e = 1'b0;
        #1;
        check("flush_busy", md_busy, 1'b0);
        check("flush_valid_m", valid_m, 1'b0);
        check("flush_keep_m", alu_result_m, exp_m);
        check("flush_stall_after", stall_ex, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of a divide.
        valid_e = 1; md_en_e = 1; md_op_e = 3'd4; rd1_e = 32'd1000; rd2_e = 32'd7;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", md_busy, 1'b0);
        check("midrst_stall", stall_ex, 1'b0);
        check("midrst_ctrl_m", {valid_m, reg_write_m, load_m, store_m, result_src_m, rd_m}, 0);
        check("midrst_data_m", {alu_result_m, write_data_m}, 0);
        check("midrst_pass_m", {pc_plus4_m, instr_m}, 0);
        valid_e = 1'b0; md_en_e = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_m = 0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic [31:0] pool [4];
            pool[0] = 32'd0; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000; pool[3] = 32'd1;
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            result_w = $urandom;
            run_instr(1'($urandom), 4'($urandom), 3'($urandom), a, b,
                      2'($urandom), 2'($urandom), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        check("end_busy", md_busy, 1'b0);
        check("end_valid_m", valid_m, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
